phase_capture: RTL and testbench

PHASE_CAPTURE -- requirements
Module: phase_capture

---
 rtl/phase_capture.sv | 148 ++++++++++++++
 tb/tb_phase_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_capture.sv
// Captures the spin vector of a converging sampler: a run ends either when the phase
// has been stable for the target number of samples or when the cycle limit expires.
module phase_capture #(
   parameter int N     = 3,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [N-1:0]     phase,
   input  logic             phase_valid,
   input  logic [CNT_W-1:0] stable_target,
   input  logic [31:0]      timeout,
   output logic             busy,
   output logic [N-1:0]     result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             converged,
   output logic             timed_out,
   output logic [31:0]      sample_count,
   output logic [1:0]       dbg_state
);

   // result_valid/result_ready: a transfer happens on an edge where both are high;
   // result_valid is a register and never depends combinationally on result_ready.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_sample_count, w_sample_count_nxt;
   logic [CNT_W-1:0] r_stable_cnt, w_stable_cnt_nxt;
   logic [31:0]      r_cycle_cnt, w_cycle_cnt_nxt;
   logic [N-1:0]     r_last_phase, w_last_phase_nxt;
   logic [N-1:0]     r_result, w_result_nxt;
   logic             r_result_valid, w_result_valid_nxt;
   logic             r_converged, w_converged_nxt;
   logic             r_timed_out, w_timed_out_nxt;

   logic [CNT_W-1:0] w_target;
   logic [CNT_W-1:0] w_stable_upd;
   logic             w_first;
   logic             w_conv;
   logic             w_tmo;

   // Bit 0 is spin 0; forcing it to 0 picks one representative of each flip pair.
   function automatic logic [N-1:0] normalize(input logic [N-1:0] v);
      return v[0] ? ~v : v;
   endfunction

   assign w_target     = (stable_target == '0) ? CNT_W'(1) : stable_target;
   // stable_cnt is 0 only before the first sample of a run.
   assign w_first      = (r_stable_cnt == '0);
   assign w_stable_upd = (w_first || (phase != r_last_phase)) ? CNT_W'(1) :
                         ((&r_stable_cnt) ? r_stable_cnt : r_stable_cnt + CNT_W'(1));
   assign w_conv       = phase_valid && (w_stable_upd >= w_target);
   assign w_tmo        = (timeout != 32'd0) && ((r_cycle_cnt + 32'd1) == timeout);

   always_comb begin
      w_state_nxt        = r_state;
      w_sample_count_nxt = r_sample_count;
      w_stable_cnt_nxt   = r_stable_cnt;
      w_cycle_cnt_nxt    = r_cycle_cnt;
      w_last_phase_nxt   = r_last_phase;
      w_result_nxt       = r_result;
      w_result_valid_nxt = r_result_valid;
      w_converged_nxt    = r_converged;
      w_timed_out_nxt    = r_timed_out;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt        = S_RUN;
               w_sample_count_nxt = '0;
               w_stable_cnt_nxt   = '0;
               w_cycle_cnt_nxt    = '0;
               w_last_phase_nxt   = '0;
               w_converged_nxt    = 1'b0;
               w_timed_out_nxt    = 1'b0;
            end
         end
         S_RUN: begin
            w_cycle_cnt_nxt = r_cycle_cnt + 32'd1;
            if (phase_valid) begin
               w_sample_count_nxt = (&r_sample_count) ? r_sample_count : r_sample_count + 32'd1;
               w_stable_cnt_nxt   = w_stable_upd;
               w_last_phase_nxt   = phase;
            end
            // Convergence takes priority over a timeout in the same cycle.
            if (w_conv) begin
               w_state_nxt        = S_HOLD;
               w_converged_nxt    = 1'b1;
               w_result_nxt       = normalize(phase);
               w_result_valid_nxt = 1'b1;
            end else if (w_tmo) begin
               w_state_nxt        = S_HOLD;
               w_timed_out_nxt    = 1'b1;
               w_result_nxt       = normalize(phase_valid ? phase : r_last_phase);
               w_result_valid_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (result_ready) begin
               w_state_nxt        = S_IDLE;
               w_result_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt        = S_IDLE;
            w_result_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state        <= S_IDLE;
         r_sample_count <= '0;
         r_stable_cnt   <= '0;
         r_cycle_cnt    <= '0;
         r_last_phase   <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_converged    <= 1'b0;
         r_timed_out    <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_sample_count <= w_sample_count_nxt;
         r_stable_cnt   <= w_stable_cnt_nxt;
         r_cycle_cnt    <= w_cycle_cnt_nxt;
         r_last_phase   <= w_last_phase_nxt;
         r_result       <= w_result_nxt;
         r_result_valid <= w_result_valid_nxt;
         r_converged    <= w_converged_nxt;
         r_timed_out    <= w_timed_out_nxt;
      end
   end

   assign busy         = (r_state != S_IDLE);
   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign converged    = r_converged;
   assign timed_out    = r_timed_out;
   assign sample_count = r_sample_count;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_phase_capture.sv
// Directed bench for phase_capture: results are predicted into a queue when a run is
// driven and popped when result_valid rises. Spin vectors are written spin 0 first.
module tb_phase_capture;
   localparam int N     = 3;
   localparam int CNT_W = 16;
   localparam int W     = N + 34;

   logic             clk;
   logic             rstn;
   logic             start;
   logic [N-1:0]     phase;
   logic             phase_valid;
   logic [CNT_W-1:0] stable_target;
   logic [31:0]      timeout;
   logic             busy;
   logic [N-1:0]     result;
   logic             result_valid;
   logic             result_ready;
   logic             converged;
   logic             timed_out;
   logic [31:0]      sample_count;
   logic [1:0]       dbg_state;

   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   phase_capture #(.N(N), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .start(start), .phase(phase), .phase_valid(phase_valid),
      .stable_target(stable_target), .timeout(timeout), .busy(busy), .result(result),
      .result_valid(result_valid), .result_ready(result_ready), .converged(converged),
      .timed_out(timed_out), .sample_count(sample_count), .dbg_state(dbg_state)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed running, expected done");
      $fatal(1, "watchdog");
   end

   // Spin-0-first notation to the packed vector (spin 0 at bit 0).
   function automatic logic [2:0] sp(input logic [2:0] s);
      return {s[0], s[1], s[2]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Driver tasks
   task automatic start_run(input logic [CNT_W-1:0] tgt, input logic [31:0] tmo);
      stable_target = tgt;
      timeout       = tmo;
      start         = 1'b1;
      step();
      start         = 1'b0;
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_state", 64'(dbg_state), 64'd1);
      chk("run_cnt_clear", 64'(sample_count), 64'd0);
      chk("run_flags_clear", 64'({converged, timed_out}), 64'd0);
   endtask

   task automatic send(input logic [N-1:0] ph);
      phase       = ph;
      phase_valid = 1'b1;
      step();
      phase_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      phase_valid = 1'b0;
      step();
   endtask

   task automatic push_exp(input logic [N-1:0] res, input logic c, input logic t,
                           input logic [31:0] cnt);
      exp_q.push_back({res, c, t, cnt});
   endtask

   // Scoreboard pop/compare at the cycle the result must appear
   task automatic check_out(input string tag);
      logic [W-1:0] e;
      chk({tag, "_valid"}, 64'(result_valid), 64'd1);
      chk({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_result"}, 64'(result), 64'(e[W-1 -: N]));
         chk({tag, "_conv"}, 64'(converged), 64'(e[33]));
         chk({tag, "_tmo"}, 64'(timed_out), 64'(e[32]));
         chk({tag, "_count"}, 64'(sample_count), 64'(e[31:0]));
      end
   endtask

   task automatic accept(input string tag);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk({tag, "_acc_valid"}, 64'(result_valid), 64'd0);
      chk({tag, "_acc_busy"}, 64'(busy), 64'd0);
      chk({tag, "_acc_state"}, 64'(dbg_state), 64'd0);
   endtask

   initial begin
      logic [N-1:0] held;
      rstn          = 1'b1;
      start         = 1'b0;
      phase         = '0;
      phase_valid   = 1'b0;
      stable_target = '0;
      timeout       = '0;
      result_ready  = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(result_valid), 64'd0);
      chk("rst_outs", 64'({result, converged, timed_out, sample_count}), 64'd0);
      step();
      step();
      rstn = 1'b1;
      step();
      chk("idle_wait", 64'(busy), 64'd0);

      // Stable 101 x3, target 3: converges on the third sample
      start_run(16'd3, 32'd0);
      push_exp(3'b010, 1'b1, 1'b0, 32'd3);
      send(sp(3'b101));
      send(sp(3'b101));
      chk("t1_early_valid", 64'(result_valid), 64'd0);
      send(sp(3'b101));
      check_out("t1");
      accept("t1");
      chk("t1_hold_result", 64'(result), 64'd2);

      // Changing phase restarts the stability count; then back-pressure in HOLD
      start_run(16'd3, 32'd0);
      push_exp(sp(3'b011), 1'b1, 1'b0, 32'd6);
      send(sp(3'b001));
      send(sp(3'b011));
      send(sp(3'b011));
      send(sp(3'b100));
      idle_cycle();
      send(sp(3'b100));
      chk("t2_early_valid", 64'(result_valid), 64'd0);
      send(sp(3'b100));
      check_out("t2");
      held = result;
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         step();
         start = 1'b0;
         chk("t2_hold_valid", 64'(result_valid), 64'd1);
         chk("t2_hold_result", 64'(result), 64'(sp(3'b011)));
      end
      chk("t2_start_ignored", 64'(sample_count), 64'd6);
      accept("t2");
      chk("t2_idle_result", 64'(result), 64'(held));
      chk("t2_idle_count", 64'(sample_count), 64'd6);
      chk("t2_idle_conv", 64'(converged), 64'd1);

      // Alternating phase never settles; the 10-cycle limit ends the run
      start_run(16'd3, 32'd10);
      push_exp(3'b000, 1'b0, 1'b1, 32'd10);
      for (int i = 0; i < 10; i++) begin
         send(((i % 2) == 0) ? 3'b000 : 3'b111);
         if (i < 9) chk("t3_no_valid", 64'(result_valid), 64'd0);
      end
      check_out("t3");
      accept("t3");

      // Convergence and timeout on the same cycle: convergence wins
      start_run(16'd2, 32'd2);
      push_exp(sp(3'b001), 1'b1, 1'b0, 32'd2);
      send(sp(3'b110));
      send(sp(3'b110));
      check_out("t4");
      accept("t4");

      // Timeout with no sample that cycle reports the last sample seen
      start_run(16'd5, 32'd4);
      push_exp(sp(3'b011), 1'b0, 1'b1, 32'd2);
      send(sp(3'b100));
      send(sp(3'b100));
      idle_cycle();
      chk("t5_no_valid", 64'(result_valid), 64'd0);
      idle_cycle();
      check_out("t5");
      accept("t5");

      // Target 0 behaves as 1: the first sample converges
      start_run(16'd0, 32'd0);
      push_exp(3'b100, 1'b1, 1'b0, 32'd1);
      send(3'b011);
      check_out("t6");
      accept("t6");

      // Reset mid-run clears outputs without a clock edge, then a clean run
      start_run(16'd3, 32'd0);
      send(3'b001);
      send(3'b001);
      #2 rstn = 1'b0;
      #1;
      chk("t7_async_busy", 64'(busy), 64'd0);
      chk("t7_async_outs", 64'({result, result_valid, converged, timed_out, sample_count}), 64'd0);
      step();
      step();
      rstn = 1'b1;
      step();
      step();
      chk("t7_idle_after_rst", 64'(busy), 64'd0);
      start_run(16'd3, 32'd0);
      push_exp(3'b110, 1'b1, 1'b0, 32'd3);
      send(3'b110);
      chk("t7_first_count", 64'(sample_count), 64'd1);
      send(3'b110);
      send(3'b110);
      check_out("t7");
      accept("t7");

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
